// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: shares the register file's single 16-to-1 read mux
// between the CPU operand-fetch path and the Pong display engine.
// A read takes IDLE/CAP -> SEL (drive select) -> CAP (capture).
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; the
// default build uses fixed priority with the CPU always winning.
module regfile_read_arbiter #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              gfx_req,
    input  logic [3:0]        gfx_addr,
    output logic              gfx_gnt,
    output logic              gfx_rvalid,
    output logic [DATA_W-1:0] gfx_rdata,
    output logic [SEL_W-1:0]  reg_select,
    input  logic [DATA_W-1:0] mux_data,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEL  = 2'd1;
    localparam logic [1:0] ST_CAP  = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_GFX = 1'b1;

    // Register index 0..15 maps to one-based select 1..16; select 0 means no register.
    function automatic logic [SEL_W-1:0] idx_to_sel(input logic [3:0] idx);
        return {{(SEL_W-4){1'b0}}, idx} + {{(SEL_W-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]        state_r;
    logic              owner_r;

    logic [1:0]        state_s;
    logic              owner_s;
    logic [SEL_W-1:0]  sel_s;
    logic              busy_s;
    logic              cpu_gnt_s;
    logic              gfx_gnt_s;
    logic              cpu_rvalid_s;
    logic              gfx_rvalid_s;
    logic [DATA_W-1:0] cpu_rdata_s;
    logic [DATA_W-1:0] gfx_rdata_s;
    logic              arb_s;
    logic              grant_cpu_s;
    logic              grant_gfx_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic              prio_r;
    logic              prio_s;

    // Round-robin winner: on a tie the pointer picks, otherwise the lone requester wins.
    always_comb begin
        if (cpu_req && gfx_req) begin
            grant_cpu_s = (prio_r == OWN_CPU);
        end else begin
            grant_cpu_s = cpu_req;
        end
        grant_gfx_s = gfx_req && !grant_cpu_s;
    end
`else
    // Fixed priority winner: the CPU always wins, the display engine takes leftovers.
    always_comb begin
        grant_cpu_s = cpu_req;
        grant_gfx_s = gfx_req && !grant_cpu_s;
    end
`endif

    // Next-state and next-output logic for the IDLE/SEL/CAP sequencer.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        sel_s        = reg_select;
        busy_s       = busy;
        cpu_gnt_s    = 1'b0;
        gfx_gnt_s    = 1'b0;
        cpu_rvalid_s = 1'b0;
        gfx_rvalid_s = 1'b0;
        cpu_rdata_s  = cpu_rdata;
        gfx_rdata_s  = gfx_rdata;
        arb_s        = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        prio_s       = prio_r;
`endif
        case (state_r)
            ST_IDLE: begin
                arb_s = 1'b1;
            end
            ST_SEL: begin
                // Settle cycle: select held, requests ignored.
                state_s = ST_CAP;
            end
            ST_CAP: begin
                arb_s = 1'b1;
                if (owner_r == OWN_CPU) begin
                    cpu_rvalid_s = 1'b1;
                    cpu_rdata_s  = mux_data;
                end else begin
                    gfx_rvalid_s = 1'b1;
                    gfx_rdata_s  = mux_data;
                end
            end
            default: begin
                state_s = ST_IDLE;
                sel_s   = {SEL_W{1'b0}};
                busy_s  = 1'b0;
            end
        endcase

        if (arb_s) begin
            if (grant_cpu_s) begin
                state_s   = ST_SEL;
                owner_s   = OWN_CPU;
                sel_s     = idx_to_sel(cpu_addr);
                busy_s    = 1'b1;
                cpu_gnt_s = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                prio_s    = OWN_GFX;
`endif
            end else if (grant_gfx_s) begin
                state_s   = ST_SEL;
                owner_s   = OWN_GFX;
                sel_s     = idx_to_sel(gfx_addr);
                busy_s    = 1'b1;
                gfx_gnt_s = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                prio_s    = OWN_CPU;
`endif
            end else begin
                state_s = ST_IDLE;
                sel_s   = {SEL_W{1'b0}};
                busy_s  = 1'b0;
            end
        end else begin
            // Grants are only issued on edges that leave IDLE or CAP.
            cpu_gnt_s = 1'b0;
            gfx_gnt_s = 1'b0;
        end
    end

    // State and output registers; reset aborts any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            owner_r    <= OWN_CPU;
            reg_select <= {SEL_W{1'b0}};
            busy       <= 1'b0;
            cpu_gnt    <= 1'b0;
            gfx_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            gfx_rvalid <= 1'b0;
            cpu_rdata  <= {DATA_W{1'b0}};
            gfx_rdata  <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            prio_r     <= OWN_CPU;
`endif
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            reg_select <= sel_s;
            busy       <= busy_s;
            cpu_gnt    <= cpu_gnt_s;
            gfx_gnt    <= gfx_gnt_s;
            cpu_rvalid <= cpu_rvalid_s;
            gfx_rvalid <= gfx_rvalid_s;
            cpu_rdata  <= cpu_rdata_s;
            gfx_rdata  <= gfx_rdata_s;
`ifdef ARB_ROUND_ROBIN_EN
            prio_r     <= prio_s;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter. Builds with or without
// ARB_ROUND_ROBIN_EN; expectations follow the same macro.
module tb_regfile_read_arbiter;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic [3:0]        cpu_addr = 4'd0;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              gfx_req = 1'b0;
    logic [3:0]        gfx_addr = 4'd0;
    logic              gfx_gnt;
    logic              gfx_rvalid;
    logic [DATA_W-1:0] gfx_rdata;
    logic [SEL_W-1:0]  reg_select;
    logic [DATA_W-1:0] mux_data;
    logic              busy;

    logic [15:0] rf [0:15];
    int vectors = 0;
    int miscompares = 0;

    regfile_read_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_gnt(gfx_gnt),
        .gfx_rvalid(gfx_rvalid), .gfx_rdata(gfx_rdata),
        .reg_select(reg_select), .mux_data(mux_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file read mux: select 1..16 picks r0..r15, anything else reads zero.
    always_comb begin
        mux_data = 16'h0000;
        if (reg_select >= 5'd1 && reg_select <= 5'd16) mux_data = rf[4'(reg_select - 5'd1)];
    end

    // Transaction-level reference: a read occupies the port for two edges after its grant.
    typedef struct {
        int         left;
        logic       owner;
        logic [3:0] idx;
        logic       pref;
        logic       cg, gg, cv, gv, busy;
        logic [4:0] sel;
        logic [15:0] crd, grd;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_reset();
        mdl_t r;
        r.left = 0; r.owner = 1'b0; r.idx = 4'd0; r.pref = 1'b0;
        r.cg = 1'b0; r.gg = 1'b0; r.cv = 1'b0; r.gv = 1'b0; r.busy = 1'b0;
        r.sel = 5'd0; r.crd = 16'h0000; r.grd = 16'h0000;
        return r;
    endfunction

    function automatic mdl_t model_step(input mdl_t cur, input logic creq, input logic [3:0] caddr,
                                        input logic greq, input logic [3:0] gaddr);
        mdl_t n;
        logic win_cpu, win_gfx;
        n = cur;
        n.cg = 1'b0; n.gg = 1'b0; n.cv = 1'b0; n.gv = 1'b0;
        if (n.left == 1) begin
            if (n.owner == 1'b0) begin n.cv = 1'b1; n.crd = rf[n.idx]; end
            else begin n.gv = 1'b1; n.grd = rf[n.idx]; end
            n.left = 0;
        end else if (n.left == 2) begin
            n.left = 1;
        end
        if (n.left == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_cpu = (creq && greq) ? (n.pref == 1'b0) : creq;
`else
            win_cpu = creq;
`endif
            win_gfx = greq && !win_cpu;
            if (win_cpu) begin
                n.left = 2; n.owner = 1'b0; n.idx = caddr; n.cg = 1'b1;
                n.sel = 5'(caddr) + 5'd1; n.busy = 1'b1; n.pref = 1'b1;
            end else if (win_gfx) begin
                n.left = 2; n.owner = 1'b1; n.idx = gaddr; n.gg = 1'b1;
                n.sel = 5'(gaddr) + 5'd1; n.busy = 1'b1; n.pref = 1'b0;
            end else begin
                n.sel = 5'd0; n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, cpu_req, cpu_addr, gfx_req, gfx_addr);
    end

    logic [41:0] exp_obs;
    logic [41:0] dut_obs;
    always_comb exp_obs = {m.cg, m.gg, m.cv, m.gv, m.busy, m.sel, m.crd, m.grd};
    always_comb dut_obs = {cpu_gnt, gfx_gnt, cpu_rvalid, gfx_rvalid, busy, reg_select, cpu_rdata, gfx_rdata};

    task automatic drain();
        cpu_req = 1'b0;
        gfx_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b1; gfx_req = 1'b1; cpu_addr = 4'd3; gfx_addr = 4'd7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== 42'h0) begin
                miscompares++;
                $display("FAIL reset_hold: got %h expected %h", dut_obs, 42'h0);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cpu_gnt, gfx_gnt, reg_select} !== {1'b1, 1'b0, 5'd4}) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b expected %b", {cpu_gnt, gfx_gnt, reg_select}, {1'b1, 1'b0, 5'd4});
        end
        cpu_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs) begin
                miscompares++;
                $display("FAIL reset_model: got %h expected %h", dut_obs, exp_obs);
            end
            if (gfx_gnt) gfx_req = 1'b0;
        end
        drain();
    endtask

    task automatic test_single_cpu();
        logic [31:0] got, want;
        rf[5] = 16'hBEEF;
        cpu_req = 1'b1; cpu_addr = 4'd5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs) begin
                miscompares++;
                $display("FAIL single_model: got %h expected %h", dut_obs, exp_obs);
            end
            got = 32'h0; want = 32'h0;
            case (k)
                0: begin got = 32'({cpu_gnt, busy, reg_select}); want = 32'({1'b1, 1'b1, 5'd6}); cpu_req = 1'b0; end
                1: begin got = 32'({cpu_gnt, cpu_rvalid, busy, reg_select}); want = 32'({1'b0, 1'b0, 1'b1, 5'd6}); end
                2: begin got = 32'({cpu_rvalid, busy, reg_select, cpu_rdata}); want = 32'({1'b1, 1'b0, 5'd0, 16'hBEEF}); end
                default: begin got = 32'({cpu_rvalid, cpu_rdata}); want = 32'({1'b0, 16'hBEEF}); end
            endcase
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL single_step%0d: got %h expected %h", k, got, want);
            end
        end
        drain();
    endtask

    task automatic test_edge_index();
        rf[15] = 16'h1234;
        gfx_req = 1'b1; gfx_addr = 4'd15;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs) begin
                miscompares++;
                $display("FAIL edge_model: got %h expected %h", dut_obs, exp_obs);
            end
            if (k == 0) begin
                vectors++;
                if ({gfx_gnt, reg_select} !== {1'b1, 5'b10000}) begin
                    miscompares++;
                    $display("FAIL edge_select: got %b expected %b", {gfx_gnt, reg_select}, {1'b1, 5'b10000});
                end
                gfx_req = 1'b0;
            end else if (k == 2) begin
                vectors++;
                if ({gfx_rvalid, gfx_rdata} !== {1'b1, 16'h1234}) begin
                    miscompares++;
                    $display("FAIL edge_rdata: got %h expected %h", {gfx_rvalid, gfx_rdata}, {1'b1, 16'h1234});
                end
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] v0, v1;
        int rv_at [$];
        v0 = 16'($urandom) | 16'h0001;
        v1 = 16'($urandom) | 16'h8000;
        rf[0] = v0; rf[1] = v1;
        cpu_req = 1'b1; cpu_addr = 4'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs) begin
                miscompares++;
                $display("FAIL b2b_model: got %h expected %h", dut_obs, exp_obs);
            end
            if (cpu_rvalid) rv_at.push_back(k);
            if (k < 4) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_busy: got %b expected 1 at step %0d", busy, k);
                end
            end
            if (k == 0) cpu_addr = 4'd1;
            if (k == 2) begin
                vectors++;
                if ({cpu_rvalid, cpu_rdata, cpu_gnt} !== {1'b1, v0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL b2b_first: got %h expected %h", {cpu_rvalid, cpu_rdata, cpu_gnt}, {1'b1, v0, 1'b1});
                end
                cpu_req = 1'b0;
            end
            if (k == 4) begin
                vectors++;
                if ({cpu_rvalid, cpu_rdata} !== {1'b1, v1}) begin
                    miscompares++;
                    $display("FAIL b2b_second: got %h expected %h", {cpu_rvalid, cpu_rdata}, {1'b1, v1});
                end
            end
        end
        vectors++;
        if (rv_at.size() != 2 || (rv_at.size() == 2 && rv_at[1] - rv_at[0] != 2)) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d rvalids expected 2 spaced by 2", rv_at.size());
        end
        drain();
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_addr = 4'($urandom_range(0, 15));
        @(negedge clk);
        vectors++;
        if (cpu_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_grant: got %b expected 1", cpu_gnt);
        end
        cpu_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({reg_select, busy, cpu_gnt, cpu_rvalid, cpu_rdata} !== 24'h0) begin
            miscompares++;
            $display("FAIL midrst_async: got %h expected %h", {reg_select, busy, cpu_gnt, cpu_rvalid, cpu_rdata}, 24'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({cpu_rvalid, gfx_rvalid, dut_obs} !== {2'b00, exp_obs}) begin
                miscompares++;
                $display("FAIL midrst_after: got %h expected %h", {cpu_rvalid, gfx_rvalid, dut_obs}, {2'b00, exp_obs});
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0] cg_bits, gg_bits;
        logic [15:0] want;
        cg_bits = 8'h00; gg_bits = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cpu_req = 1'b1; gfx_req = 1'b1;
        cpu_addr = 4'($urandom_range(0, 15)); gfx_addr = 4'($urandom_range(0, 15));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs) begin
                miscompares++;
                $display("FAIL contend_model: got %h expected %h", dut_obs, exp_obs);
            end
            cg_bits[k] = cpu_gnt;
            gg_bits[k] = gfx_gnt;
        end
`ifdef ARB_ROUND_ROBIN_EN
        want = {8'b0001_0001, 8'b0100_0100};
`else
        want = {8'b0101_0101, 8'b0000_0000};
`endif
        vectors++;
        if ({cg_bits, gg_bits} !== want) begin
            miscompares++;
            $display("FAIL contend_order: got cpu=%b gfx=%b expected cpu=%b gfx=%b", cg_bits, gg_bits, want[15:8], want[7:0]);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs) begin
                miscompares++;
                $display("FAIL random_model: cycle %0d got %h expected %h", k, dut_obs, exp_obs);
            end
            if (cpu_req && cpu_gnt) begin
                cpu_req = 1'($urandom_range(0, 1)); cpu_addr = 4'($urandom_range(0, 15));
            end else if (!cpu_req) begin
                cpu_req = ($urandom_range(0, 2) == 0); cpu_addr = 4'($urandom_range(0, 15));
            end
            if (gfx_req && gfx_gnt) begin
                gfx_req = 1'($urandom_range(0, 1)); gfx_addr = 4'($urandom_range(0, 15));
            end else if (!gfx_req) begin
                gfx_req = ($urandom_range(0, 2) == 0); gfx_addr = 4'($urandom_range(0, 15));
            end
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h0101 + 16'h0011);
        test_reset();
        test_single_cpu();
        test_edge_index();
        test_back_to_back();
        test_reset_mid();
        test_contention();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
